ifu: RTL

Instruction fetch unit: owns the program counter, drives the instruction bus, and holds the IF/ID pipeline register. It sits directly upstream of decode and obeys the `if_flush` and `if_stall` controls from the hazard detection unit. Its `ibus_waitrequest` input is the same signal the hazard unit uses to build those controls. It accepts branch and trap redirects, including while a bus transaction is held off by wait states.

---
 rtl/ifu.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu - instruction fetch unit
//
// Owns the program counter, drives a read-only instruction bus with wait
// states, and holds the IF/ID pipeline register feeding decode.
//
// Ports
//   clk, rst_b        core clock, asynchronous active-low reset
//   if_stall          hold PC and IF/ID (from hazard unit)
//   if_flush          force a bubble into IF/ID (from hazard unit)
//   branch_take/target  branch or jump redirect
//   trap_take/target    trap or mret redirect, wins over a branch
//   ibus_read         read request (registered)
//   ibus_address      word-aligned fetch address, straight from the PC
//   ibus_readdata     instruction word, valid on read && !waitrequest
//   ibus_waitrequest  slave wait state
//   id_valid/pc/instr IF/ID entry (registered)
// ---------------------------------------------------------------------------
module ifu #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            if_stall,
    input  logic            if_flush,
    input  logic            branch_take,
    input  logic [XLEN-1:0] branch_target,
    input  logic            trap_take,
    input  logic [XLEN-1:0] trap_target,
    output logic            ibus_read,
    output logic [XLEN-1:0] ibus_address,
    input  logic [XLEN-1:0] ibus_readdata,
    input  logic            ibus_waitrequest,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_target;
    logic            r_ibus_read;
    logic            r_id_valid;
    logic [XLEN-1:0] r_id_pc;
    logic [XLEN-1:0] r_id_instr;

    logic            w_redirect;
    logic [XLEN-1:0] w_target_raw;
    logic [XLEN-1:0] w_target;
    logic            w_complete;
    logic            w_fetch_done;

    assign w_redirect   = trap_take | branch_take;
    assign w_target_raw = trap_take ? trap_target : branch_target;
    // Instructions are word aligned, so the low target bits are dropped
    // before they ever reach the PC.
    assign w_target     = {w_target_raw[XLEN-1:2], 2'b00};
    assign w_complete   = r_ibus_read & ~ibus_waitrequest;
    // Only a word fetched in FETCH with no redirect in flight is real; a word
    // completing in REDIRECT belongs to the abandoned path.
    assign w_fetch_done = (r_state == S_FETCH) & w_complete & ~w_redirect;

    // Fetch sequencer: state, PC, pending redirect target, bus request.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state       <= S_IDLE;
            r_pc          <= PC_RESET;
            r_pend_target <= '0;
            r_ibus_read   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_FETCH;
                    r_ibus_read <= 1'b1;
                end
                S_FETCH: begin
                    if (w_redirect) begin
                        // The address must stay stable under a wait state,
                        // so a redirect then is parked until completion.
                        if (ibus_waitrequest) begin
                            r_pend_target <= w_target;
                            r_state       <= S_REDIRECT;
                        end else begin
                            r_pc <= w_target;
                        end
                    end else if (w_complete && !if_stall) begin
                        r_pc <= r_pc + XLEN'(4);
                    end
                    // Completion under if_stall leaves the PC alone, so the
                    // same word is simply read again.
                end
                S_REDIRECT: begin
                    if (w_complete) begin
                        // A redirect arriving on the completion cycle is the
                        // youngest request and therefore wins.
                        r_pc    <= w_redirect ? w_target : r_pend_target;
                        r_state <= S_FETCH;
                    end else if (w_redirect) begin
                        r_pend_target <= w_target;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_ibus_read <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_instr <= '0;
        end else if (if_flush) begin
            r_id_valid <= 1'b0;
        end else if (if_stall) begin
            r_id_valid <= r_id_valid;
        end else if (w_fetch_done) begin
            r_id_valid <= 1'b1;
            r_id_pc    <= r_pc;
            r_id_instr <= ibus_readdata;
        end else begin
            r_id_valid <= 1'b0;
        end
    end

    assign ibus_read    = r_ibus_read;
    assign ibus_address = {r_pc[XLEN-1:2], 2'b00};
    assign id_valid     = r_id_valid;
    assign id_pc        = r_id_pc;
    assign id_instr     = r_id_instr;

endmodule
